inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Byte-stream program loader: the write side of the byte-addressed, big-endian instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte into the memory's byte write port, in stream order, starting at address 0.
- Holds the CPU in reset until a complete, checksum-verified image has been written.
- Sits between the host/debug link and instruction memory; fetch reads the image back as {mem[a],mem[a+1],mem[a+2],mem[a+3]}.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes (multiple of 4)
MAX_WORDS, MEM_BYTES/4, largest accepted image in 32-bit words

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begin a load
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte
wr_en  out  1  one-cycle byte write strobe to instruction memory
wr_addr  out  32  byte address for the write
wr_data  out  8  byte to write
cpu_hold  out  1  keeps the CPU in reset while high
done  out  1  sticky, image loaded and checksum good
err  out  1  sticky, oversize header or bad checksum
words_loaded  out  16  words fully written in the current load

Behaviour:
- Frame format: LEN_HI, LEN_LO (N = big-endian word count), then 4N data bytes, then CSUM.
  - CSUM = XOR of every preceding frame byte (header included).
- Transfer: occurs on a rising edge with in_valid & in_ready.
  - in_data must hold while in_valid is high and in_ready is low.
  - in_valid may drop between bytes.
- Reset (rst=0, async): state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0, words_loaded=0, internal byte counter=0, checksum accumulator=0.
- States: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
  - in_ready=1 only in HDR_HI, HDR_LO, DATA and CSUM.
- IDLE: start -> HDR_HI. Clear the byte counter, accumulator, done, err and words_loaded. cpu_hold stays 1.
- HDR_HI: transfer latches LEN_HI -> HDR_LO.
- HDR_LO: transfer latches LEN_LO.
  - N > MAX_WORDS -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: each transfer registers wr_en=1, wr_addr=byte counter, wr_data=in_data on the same edge, so the write is visible the cycle after acceptance.
  - The byte counter then increments.
  - wr_en is high for exactly one cycle per accepted byte, and 0 otherwise.
  - words_loaded increments when the counter crosses a multiple of 4.
  - After byte 4N-1 is accepted -> CSUM.
- CSUM: transfer compares in_data with the accumulator.
  - Match -> DONE.
  - Mismatch -> ERR.
- DONE: done=1, cpu_hold=0 (registered, from the edge that accepted CSUM).
- ERR: err=1, cpu_hold=1, no further writes. Bytes already written stay in memory.
- start in DONE or ERR: restart the frame as from IDLE, with done=0, err=0, cpu_hold=1 on the next cycle.
- start in HDR_HI, HDR_LO, DATA or CSUM: ignored.
- Accumulator: XORs every accepted byte before the CSUM byte.
- Byte counter width: must cover 4*MAX_WORDS without wrap. wr_addr is the counter zero-extended to 32 bits.
- Reset mid-load: immediate return to reset values. A partially written image is left in memory; cpu_hold=1.
- Simultaneous start and transfer in IDLE: the byte is not accepted, because in_ready=0 in IDLE.

Test Plan:
1. Two-word image: start, then stream 00 02 00 10 03 13 00 63 03 33 51 with in_valid held high.
   -> 8 wr_en pulses, addr 0..7, data 00 10 03 13 00 63 03 33.
   -> words_loaded=2, done=1, err=0, cpu_hold=0 one cycle after the CSUM byte is accepted.
2. Same stream with CSUM=50 -> the same 8 writes occur, then err=1, done=0, cpu_hold=1.
3. Oversize: header 01 01 (257 > 256) -> err=1 right after the second byte, zero wr_en pulses, in_ready=0.
4. Empty image: header 00 00, CSUM 00 -> done=1, cpu_hold=0, zero writes.
5. Backpressure and gaps: the case 1 stream with random in_valid gaps -> identical write sequence and result.
6. Reset: rst low after the 3rd data byte -> all outputs return to reset values asynchronously.
   Then a fresh start plus the case 1 stream -> addresses restart at 0 and done=1.
   Then start from DONE with the case 4 stream -> done drops, cpu_hold=1, then done=1 again.

Source files
------------

// File: rtl/inst_loader.sv
// Framed byte-stream program loader: writes a checksum-protected image into
// instruction memory from address 0 and holds the CPU in reset until it is good.
module inst_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_WORDS = MEM_BYTES / 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam int CW = $clog2(4 * MAX_WORDS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [15:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d;
  logic          rdy_q, rdy_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   words_q, words_d;

  logic          xfer_s;
  logic          restart_s;
  logic          last_byte_s;
  logic [31:0]   hdr_len_s;

  assign xfer_s      = in_valid & rdy_q;
  assign restart_s   = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
  assign last_byte_s = ({{(32-CW){1'b0}}, cnt_q} == ({14'd0, len_q, 2'b00} - 32'd1));
  assign hdr_len_s   = {16'd0, len_hi_q, in_data};

  // Next-state and output decode for the frame parser.
  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    words_d   = words_q;

    case (state_q)
      S_HDR_HI: begin
        if (xfer_s) begin
          len_hi_d = in_data;
          acc_d    = acc_q ^ in_data;
          state_d  = S_HDR_LO;
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_HDR_LO: begin
        if (xfer_s) begin
          len_d = hdr_len_s[15:0];
          acc_d = acc_q ^ in_data;
          if (hdr_len_s > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else if (hdr_len_s == 32'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {{(32-CW){1'b0}}, cnt_q};
          wr_data_d = in_data;
          cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          acc_d     = acc_q ^ in_data;
          if (cnt_q[1:0] == 2'b11) begin
            words_d = words_q + 16'd1;
          end else begin
            words_d = words_q;
          end
          if (last_byte_s) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer_s) begin
          if (in_data == acc_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      S_IDLE, S_DONE, S_ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new load may only begin from an idle or finished state.
    if (restart_s) begin
      state_d = S_HDR_HI;
      cnt_d   = '0;
      acc_d   = 8'd0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      hold_d  = 1'b1;
      words_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end

    rdy_d = (state_d == S_HDR_HI) | (state_d == S_HDR_LO) |
            (state_d == S_DATA)   | (state_d == S_CSUM);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_hi_q  <= 8'd0;
      len_q     <= 16'd0;
      cnt_q     <= '0;
      acc_q     <= 8'd0;
      rdy_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 8'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rdy_q     <= rdy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      words_q   <= words_d;
    end
  end

  assign in_ready     = rdy_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Table-driven bench for inst_loader with a write scoreboard fed at stimulus time.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  typedef struct {
    int               nbytes;
    logic [0:11][7:0] b;
    bit               gaps;
    bit               exp_done;
    bit               exp_err;
    int               exp_words;
  } vec_t;

  vec_t vecs[5];

  inst_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected none", wr_addr, wr_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("write_addr", wr_addr, e[39:8]);
        chk("write_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        in_valid = 1'b0;
        in_data  = 8'hxx;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic run_vec(input int k, input int stop_after);
    vec_t v;
    int   nw;
    v  = vecs[k];
    nw = int'({v.b[0], v.b[1]});
    pulse_start();
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
    chk("restart_words", {16'd0, words_loaded}, 32'd0);
    for (int i = 0; i < v.nbytes && i < stop_after; i++) begin
      if (nw <= 256 && i >= 2 && i < 2 + 4 * nw) begin
        exp_q.push_back({32'(i - 2), v.b[i]});
      end
      if (i == v.nbytes - 1 && nw <= 256) begin
        chk("hold_before_csum", {31'd0, cpu_hold}, 32'd1);
        chk("done_before_csum", {31'd0, done}, 32'd0);
      end
      send_byte(v.b[i], v.gaps);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // two words, good checksum
    vecs[0] = '{11, {8'h00, 8'h02, 8'h00, 8'h10, 8'h03, 8'h13, 8'h00, 8'h63, 8'h03, 8'h33, 8'h51, 8'h00},
                1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{11, {8'h00, 8'h02, 8'h00, 8'h10, 8'h03, 8'h13, 8'h00, 8'h63, 8'h03, 8'h33, 8'h50, 8'h00},
                1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{2, {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{3, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                1'b0, 1'b1, 1'b0, 0};
    vecs[4] = vecs[0];
    vecs[4].gaps = 1'b1;

    #12;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_vec(k, 99);
      @(negedge clk);
      chk($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, vecs[k].exp_done});
      chk($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
      chk($sformatf("v%0d_hold", k), {31'd0, cpu_hold}, {31'd0, ~vecs[k].exp_done});
      chk($sformatf("v%0d_words", k), {16'd0, words_loaded}, 32'(vecs[k].exp_words));
      chk($sformatf("v%0d_ready", k), {31'd0, in_ready}, 32'd0);
      #1;
      chk($sformatf("v%0d_pending", k), 32'(exp_q.size()), 32'd0);
    end

    // Reset after the third data byte.
    run_vec(0, 5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_addr", wr_addr, 32'd0);
    chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
    chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
    chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_vec(0, 99);
    @(negedge clk);
    chk("after_rst_done", {31'd0, done}, 32'd1);
    chk("after_rst_words", {16'd0, words_loaded}, 32'd2);

    run_vec(3, 99);
    @(negedge clk);
    chk("reload_done", {31'd0, done}, 32'd1);
    chk("reload_hold", {31'd0, cpu_hold}, 32'd0);
    chk("reload_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
